// File: rtl/reaction_controller.sv
// Reaction-time game controller: a random delay, then the LED lights and the
// push-button reaction time is measured in hundredths of a second. The best time is tracked.
module reaction_controller #(
  parameter int unsigned MIN_DLY = 100
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       c9,
  input  logic       w,
  input  logic       Pushn,
  input  logic       clr_best,
  output logic       LEDn,
  output logic [3:0] BCD1,
  output logic [3:0] BCD0,
  output logic [3:0] Best1,
  output logic [3:0] Best0,
  output logic       foul,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RND,
    TIMING,
    SHOW,
    FOUL
  } state_t;

  state_t      state_q;
  logic        w_q;
  logic        armed_q;
  logic [7:0]  lfsr_q;
  logic [7:0]  lfsr_d;
  logic [9:0]  dly_q;
  logic [3:0]  bcd1_q, bcd0_q;
  logic [3:0]  best1_q, best0_q;
  logic        best_vld_q;
  logic        led_q, foul_q, busy_q;
  logic        start;

  // armed_q blocks a start until w has been seen low after reset, so a
  // level held high across reset release cannot fake a rising edge.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    start  = w & ~w_q & armed_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      w_q        <= 1'b0;
      armed_q    <= 1'b0;
      lfsr_q     <= 8'h01;
      dly_q      <= '0;
      bcd1_q     <= '0;
      bcd0_q     <= '0;
      best1_q    <= 4'd9;
      best0_q    <= 4'd9;
      best_vld_q <= 1'b0;
      led_q      <= 1'b1;
      foul_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      w_q     <= w;
      armed_q <= armed_q | ~w;
      lfsr_q  <= lfsr_d;
      case (state_q)
        IDLE, SHOW, FOUL: begin
          if (start) begin
            state_q <= WAIT_RND;
            dly_q   <= 10'(MIN_DLY) + {2'b00, lfsr_q};
            bcd1_q  <= '0;
            bcd0_q  <= '0;
            led_q   <= 1'b1;
            foul_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        WAIT_RND: begin
          if (!Pushn) begin
            state_q <= FOUL;
            bcd1_q  <= '0;
            bcd0_q  <= '0;
            foul_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (c9) begin
            dly_q <= dly_q - 10'd1;
            if (dly_q == 10'd1) begin
              state_q <= TIMING;
              led_q   <= 1'b0;
            end
          end
        end
        TIMING: begin
          if (!Pushn) begin
            state_q <= SHOW;
            led_q   <= 1'b1;
            busy_q  <= 1'b0;
            // Concatenated BCD digits order the same way as the decimal value.
            if (!best_vld_q || ({bcd1_q, bcd0_q} < {best1_q, best0_q})) begin
              best1_q    <= bcd1_q;
              best0_q    <= bcd0_q;
              best_vld_q <= 1'b1;
            end
          end else if (c9) begin
            if (bcd1_q == 4'd9 && bcd0_q == 4'd9) begin
              state_q <= SHOW;
              led_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else if (bcd0_q == 4'd9) begin
              bcd0_q <= '0;
              bcd1_q <= bcd1_q + 4'd1;
            end else begin
              bcd0_q <= bcd0_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (clr_best) begin
        best1_q    <= 4'd9;
        best0_q    <= 4'd9;
        best_vld_q <= 1'b0;
      end
    end
  end

  assign LEDn  = led_q;
  assign BCD1  = bcd1_q;
  assign BCD0  = bcd0_q;
  assign Best1 = best1_q;
  assign Best0 = best0_q;
  assign foul  = foul_q;
  assign busy  = busy_q;

endmodule

// File: doc/reaction_controller.md
REACTION_CONTROLLER -- requirements
Module: reaction_controller

Interface
REQ-001 Parameter MIN_DLY, default 100, minimum random-delay length in c9 ticks (1.00 s at 10 ms/tick).
REQ-002 Clock  in  1  system clock; all state changes on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high; clears all state immediately, independent of Clock.
REQ-004 c9  in  1  timebase enable, one-Clock-wide pulse every 10 ms.
REQ-005 w  in  1  start request (level), synchronous to Clock; only its rising edge acts.
REQ-006 Pushn  in  1  reaction push button, active-low, already debounced and synchronised.
REQ-007 clr_best  in  1  synchronous clear of best-time record.
REQ-008 LEDn  out  1  stimulus LED, active-low.
REQ-009 BCD1, BCD0  out  4 each  reaction time, tens and units of hundredths of a second.
REQ-010 Best1, Best0  out  4 each  best (lowest) valid reaction time, BCD.
REQ-011 foul  out  1  high while in FOUL state.
REQ-012 busy  out  1  high in WAIT_RND and TIMING.

Function
REQ-013 States: IDLE, WAIT_RND, TIMING, SHOW, FOUL; registered, one-hot or binary.
REQ-014 Start event = w==1 while registered w was 0; accepted in IDLE, SHOW, FOUL; ignored in WAIT_RND and TIMING.
REQ-015 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, advances every Clock, reset value 8'h01, never all-zero.
REQ-016 On start: delay counter <= MIN_DLY + LFSR value (10-bit unsigned, no overflow), BCD1/BCD0 <= 0/0, next state WAIT_RND.
REQ-017 WAIT_RND: delay counter decrements by 1 on each c9; LEDn stays 1.
REQ-018 WAIT_RND: Pushn==0 -> FOUL next cycle; priority over counter expiry in same cycle.
REQ-019 WAIT_RND: c9 while counter==1 -> TIMING; LEDn goes 0 in the same edge that enters TIMING.
REQ-020 TIMING: each c9 increments BCD0; 9->0 carries into BCD1; BCD values never exceed 9.
REQ-021 TIMING: Pushn==0 -> SHOW, digits frozen; priority over c9 in same cycle (no increment).
REQ-022 TIMING: c9 with count at 99 -> SHOW with 99 held (timeout); no best-time update.
REQ-023 Entering SHOW by push: if best invalid or count < best (strict), Best1/Best0 <= count, best valid <= 1.
REQ-024 SHOW and FOUL: LEDn=1, digits held; FOUL forces BCD1/BCD0 to 0/0.
REQ-025 clr_best==1: Best1/Best0 <= 9/9, best valid <= 0, next edge, any state; does not affect FSM.
REQ-026 Pushn held low at the start edge -> FOUL one cycle after entering WAIT_RND.
REQ-027 No combinational path from inputs to outputs; all outputs registered or decoded from state only.

Reset
REQ-028 Reset==1: state IDLE, LEDn=1, BCD1=BCD0=0, Best1=Best0=9, best valid=0, foul=0, busy=0, LFSR=8'h01, delay counter=0, registered w=0.
REQ-029 Reset asserted mid-TIMING or mid-WAIT_RND aborts immediately; no best update; release returns to IDLE awaiting a new start edge.

Verification
REQ-030 MIN_DLY=4, Pushn=1, w rising edge -> busy=1 next cycle; LEDn falls after 4..259 c9 pulses; digits 00.
REQ-031 After LEDn=0, 37 c9 pulses then Pushn=0 -> state SHOW, BCD1/BCD0=3/7, Best=3/7, LEDn=1.
REQ-032 Second run pushed at 52 ticks -> BCD=5/2, Best stays 3/7; third run at 12 -> Best=1/2; clr_best -> Best=9/9.
REQ-033 Pushn=0 during WAIT_RND -> foul=1, BCD=0/0, LEDn never 0; new w edge -> WAIT_RND, foul=0.
REQ-034 No push for 100 c9 pulses in TIMING -> SHOW with 9/9, Best unchanged; c9 and Pushn=0 same cycle at count 41 -> SHOW with 4/1.
REQ-035 Reset pulse asserted between edges mid-TIMING -> outputs at reset values before next Clock edge; w held high through release causes no start.
